// File: rtl/pbru_out_split.sv
// rtl/pbru_out_split.sv - wide-word FIFO plus serializer emitting narrow slices, lane 0 first
// Optional feature macro: PBRU_OUT_LAST_EN (adds o_ex_last, final-slice marker)
module pbru_out_split #(
  parameter int OUTPUT_WIDTH = 16,
  parameter int SET_NUMBER   = 64,
  parameter int INPUT_WIDTH  = OUTPUT_WIDTH * SET_NUMBER,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_co_wr_valid,
  input  logic [INPUT_WIDTH-1:0]  i_co_data,
  output logic                    o_co_full,
  input  logic                    i_ex_rd_ready,
  output logic                    o_ex_data_valid,
  output logic [OUTPUT_WIDTH-1:0] o_ex_data,
  output logic                    o_ex_empty
`ifdef PBRU_OUT_LAST_EN
  ,
  output logic                    o_ex_last
`endif
);

  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int SEL_WIDTH  = $clog2(SET_NUMBER);
  localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(SET_NUMBER - 1);

  // A word viewed as an array of slices; index i is lane i of the aggregator packing.
  typedef logic [SET_NUMBER-1:0][OUTPUT_WIDTH-1:0] word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Wide-word FIFO
  // ---------------------------------------------------------------------------
  word_t               mem [FIFO_DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  word_t               wr_word;
  word_t               head_word;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign fifo_full  = (rd_ptr == {~wr_ptr[ADDR_WIDTH], wr_ptr[ADDR_WIDTH-1:0]});
  assign fifo_empty = (rd_ptr == wr_ptr);

  // A write while full is dropped even if the serializer pops this same cycle.
  assign push      = i_co_wr_valid && !fifo_full;
  assign wr_word   = word_t'(i_co_data);
  assign head_word = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Storage array: written on accepted pushes, never reset (contents gated by pointers).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_word;
    end
  end

  // Pointer update: push and pop are independent, so simultaneous ones keep occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------------
  state_t               state_q;
  state_t               state_d;
  logic [SEL_WIDTH-1:0] sel_q;
  logic [SEL_WIDTH-1:0] sel_d;
  word_t                word_q;
  word_t                word_d;
  logic                 slice_taken;

  assign slice_taken = (state_q == ST_SEND) && i_ex_rd_ready;

  // Serializer state register; reset drops any partially sent word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
    end
  end

  // Next-state logic: step through slices, reload back-to-back from the FIFO with no bubble.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    word_d  = word_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          word_d  = head_word;
          sel_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (slice_taken) begin
          if (sel_q != SEL_LAST) begin
            sel_d = sel_q + SEL_WIDTH'(1);
          end else if (!fifo_empty) begin
            pop    = 1'b1;
            word_d = head_word;
            sel_d  = '0;
          end else begin
            sel_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Outputs derive only from registered state; data is forced to zero while not valid.
  assign o_ex_data_valid = (state_q == ST_SEND);
  assign o_ex_data       = o_ex_data_valid ? word_q[sel_q] : '0;
  assign o_co_full       = fifo_full;
  assign o_ex_empty      = fifo_empty && (state_q == ST_IDLE);

`ifdef PBRU_OUT_LAST_EN
  assign o_ex_last = o_ex_data_valid && (sel_q == SEL_LAST);
`endif

endmodule

// File: tb/tb_pbru_out_split.sv
// tb/tb_pbru_out_split.sv - randomized self-checking bench for pbru_out_split against a queue model
// Optional feature macro: PBRU_OUT_LAST_EN (also checks o_ex_last when defined)
module tb_pbru_out_split;

  localparam int OW = 16;
  localparam int SN = 4;
  localparam int IW = OW * SN;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [IW-1:0] wr_data;
  logic          co_full;
  logic          rd_ready;
  logic          ex_valid;
  logic [OW-1:0] ex_data;
  logic          ex_empty;
`ifdef PBRU_OUT_LAST_EN
  logic          ex_last;
`endif

  pbru_out_split #(
    .OUTPUT_WIDTH (OW),
    .SET_NUMBER   (SN),
    .INPUT_WIDTH  (IW),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_co_wr_valid   (wr_valid),
    .i_co_data       (wr_data),
    .o_co_full       (co_full),
    .i_ex_rd_ready   (rd_ready),
    .o_ex_data_valid (ex_valid),
    .o_ex_data       (ex_data),
    .o_ex_empty      (ex_empty)
`ifdef PBRU_OUT_LAST_EN
    ,
    .o_ex_last       (ex_last)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: words waiting, the word being sent and how many of its slices remain.
  logic [IW-1:0] m_fifo[$];
  logic [IW-1:0] m_cur;
  int            m_rem;
  bit            m_known;
  int            hs_count;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance both.
  task automatic cycle(input bit wv, input logic [IW-1:0] d, input bit rdy, input bit r);
    bit            exp_full;
    bit            exp_valid;
    bit            hs;
    bit            do_push;
    logic [OW-1:0] exp_slice;
    wr_valid = wv;
    wr_data  = d;
    rd_ready = rdy;
    rst      = r;
    #2;
    exp_full  = (m_fifo.size() == FD);
    exp_valid = (m_rem > 0);
    hs        = exp_valid && rdy;
    do_push   = wv && !exp_full;
    if (m_known) begin
      check("valid", 64'(ex_valid), 64'(exp_valid));
      check("full", 64'(co_full), 64'(exp_full));
      check("empty", 64'(ex_empty), 64'(m_fifo.size() == 0 && m_rem == 0));
      if (exp_valid) begin
        exp_slice = OW'(m_cur >> (OW * (SN - m_rem)));
        check("data", 64'(ex_data), 64'(exp_slice));
      end
`ifdef PBRU_OUT_LAST_EN
      check("last", 64'(ex_last), 64'(exp_valid && m_rem == 1));
`endif
      if (hs && ex_valid) hs_count++;
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_fifo.delete();
      m_rem   = 0;
      m_cur   = '0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (m_rem == 0) begin
        if (m_fifo.size() > 0) begin
          m_cur = m_fifo.pop_front();
          m_rem = SN;
        end
      end else if (hs) begin
        m_rem--;
        if (m_rem == 0 && m_fifo.size() > 0) begin
          m_cur = m_fifo.pop_front();
          m_rem = SN;
        end
      end
      if (do_push) m_fifo.push_back(d);
    end
  endtask

  function automatic logic [IW-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  initial begin
    m_known  = 1'b0;
    m_rem    = 0;
    m_cur    = '0;
    hs_count = 0;

    // T1: reset held three cycles
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    #2;
    check("t1_valid", 64'(ex_valid), 64'd0);
    check("t1_full", 64'(co_full), 64'd0);
    check("t1_empty", 64'(ex_empty), 64'd1);
    check("t1_data", 64'(ex_data), 64'd0);
    #0;

    // T2: single word, continuous ready
    cycle(1'b1, 64'h4444_3333_2222_1111, 1'b1, 1'b0);
    repeat (7) cycle(1'b0, '0, 1'b1, 1'b0);
    check("t2_empty", 64'(ex_empty), 64'd1);

    // T3: backpressure on cycles N+3..N+6
    cycle(1'b1, 64'h4444_3333_2222_1111, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b0);

    // T4: fill with ready low, extra writes dropped, exactly five words drain
    hs_count = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    check("t4_full", 64'(co_full), 64'd1);
    repeat (5 * SN + 4) cycle(1'b0, '0, 1'b1, 1'b0);
    check("t4_slices", 64'(hs_count), 64'(5 * SN));

    // T5: three queued words stream back-to-back
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    repeat (3 * SN + 3) cycle(1'b0, '0, 1'b1, 1'b0);

    // T6: reset after slice 1 of a word, then a fresh word from slice 0
    cycle(1'b1, 64'hdddd_cccc_bbbb_aaaa, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    #2;
    check("t6_valid", 64'(ex_valid), 64'd0);
    check("t6_empty", 64'(ex_empty), 64'd1);
    #0;
    cycle(1'b1, 64'h8888_7777_6666_5555, 1'b1, 1'b0);
    repeat (SN + 3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with varying ready density and rare resets
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 2) != 0), rnd_word(),
            ($urandom_range(0, 3) < ((i / 500) % 4 + 1)),
            ($urandom_range(0, 399) == 0));
    end
    repeat (FD * SN + SN + 4) cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 64'(ex_empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
